fetch_stage: RTL

- Instruction-fetch stage of the RV32I core: owns the program counter and drives the address into the combinational INSTRUCTION_MEMORY ROM.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles stall from the hazard unit and redirect from taken branches/jumps resolved in EX.
- Flushed slots become NOP bubbles (32'h0000_0013).

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id_register.sv | 36 +++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Core-wide constants and the fetch state encoding shared by the IF stage
// and the pipeline registers.
package fetch_stage_pkg;

  localparam int          DATA_WIDTH           = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// Generic pipeline register for instruction/PC/PC+4/valid with hold and
// bubble controls; bubble wins over hold so a flush is never lost to a stall.
module if_id_register
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH     = DATA_WIDTH,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             bubble,
  input  logic [WIDTH-1:0] next_instr,
  input  logic [WIDTH-1:0] next_pc,
  input  logic [WIDTH-1:0] next_pc_plus4,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (!hold) begin
      instr    <= next_instr;
      pc       <= next_pc;
      pc_plus4 <= next_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, next-PC selection and the IF/ID register.
// Optional misaligned-target trap enabled with FETCH_MISALIGN_TRAP_EN.
//
// state | meaning
// RUN   | normal fetch, redirect and stall
// HALT  | misaligned redirect seen: PC frozen, IF/ID bubbled until reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH        = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] NOP_INSTR    = WIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  output logic [WIDTH-1:0] IMEM_ADDR,
  input  logic [WIDTH-1:0] IMEM_INSTR,
  output logic [WIDTH-1:0] IF_ID_INSTR,
  output logic [WIDTH-1:0] IF_ID_PC,
  output logic [WIDTH-1:0] IF_ID_PC_PLUS4,
  output logic             IF_ID_VALID,
  output logic             FETCH_FAULT
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] target;
  logic             halted;

  assign pc_plus4  = pc + WIDTH'(4);
  assign target    = BRANCH_TARGET & ~WIDTH'(3);
  assign IMEM_ADDR = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e state;
  logic         fault;
  logic         misaligned;

  assign misaligned  = (BRANCH_TARGET[1:0] != 2'b00);
  assign halted      = (state == HALT);
  assign FETCH_FAULT = fault;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      fault <= 1'b0;
    end else begin
      case (state)
        RUN: if (BRANCH_TAKEN && misaligned) begin
          state <= HALT;
          fault <= 1'b1;
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end
`else
  assign halted      = 1'b0;
  assign FETCH_FAULT = 1'b0;
`endif

  // Redirect overrides stall; the masked target is loaded even when trapping.
  always_ff @(posedge CLK) begin
    if (RST)
      pc <= RESET_VECTOR;
    else if (halted)
      pc <= pc;
    else if (BRANCH_TAKEN)
      pc <= target;
    else if (!STALL)
      pc <= pc_plus4;
  end

  if_id_register #(
    .WIDTH     (WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk           (CLK),
    .rst           (RST),
    .hold          (STALL),
    .bubble        (BRANCH_TAKEN || halted),
    .next_instr    (IMEM_INSTR),
    .next_pc       (pc),
    .next_pc_plus4 (pc_plus4),
    .instr         (IF_ID_INSTR),
    .pc            (IF_ID_PC),
    .pc_plus4      (IF_ID_PC_PLUS4),
    .valid         (IF_ID_VALID)
  );

endmodule
